// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory controller.
// Size codes, FSM states and access byte counts.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Bytes touched by an access; 0 for the illegal size code.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        unique case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lanes.sv
// Byte-lane steering for big-endian loads and stores.
// Lane i is the byte at word base + i (lane 0 = bits 31:24).
module dmem_lanes
    import dmem_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            sgn,
    input  logic [1:0]      off,
    input  logic [31:0]     wdata,
    input  logic [3:0][7:0] rbytes,
    output logic [31:0]     rdata,
    output logic [3:0]      we,
    output logic [3:0][7:0] wb
);

    logic [1:0]  hi;
    logic [1:0]  lo;
    logic [7:0]  b;
    logic [15:0] h;

    // Halfwords are aligned, so their two lanes share off[1].
    assign hi = {off[1], 1'b0};
    assign lo = {off[1], 1'b1};
    assign b  = rbytes[off];
    assign h  = {rbytes[hi], rbytes[lo]};

    // Load data selection with optional sign extension
    always_comb begin
        rdata = '0;
        unique case (size)
            SZ_BYTE: rdata = {{24{sgn & b[7]}}, b};
            SZ_HALF: rdata = {{16{sgn & h[15]}}, h};
            SZ_WORD: rdata = {rbytes[0], rbytes[1],
                              rbytes[2], rbytes[3]};
            default: rdata = '0;
        endcase
    end

    // Store lane enables and byte placement
    always_comb begin
        we = '0;
        wb = '0;
        unique case (size)
            SZ_BYTE: begin
                we[off] = 1'b1;
                wb[off] = wdata[7:0];
            end
            SZ_HALF: begin
                we[hi] = 1'b1;
                we[lo] = 1'b1;
                wb[hi] = wdata[15:8];
                wb[lo] = wdata[7:0];
            end
            SZ_WORD: begin
                we = 4'hf;
                wb = {wdata[7:0], wdata[15:8],
                      wdata[23:16], wdata[31:24]};
            end
            default: begin
                we = '0;
                wb = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked byte-addressed data memory with wait states.
// Clears itself after reset, one word per cycle.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int NW = DEPTH_BYTES / 4;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    state_t            state;
    logic [IW-1:0]     clr_idx;
    logic [3:0]        cnt;
    logic              c_we;
    logic [1:0]        c_size;
    logic              c_signed;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;

    logic [3:0][7:0]   mem [NW];

    logic [IW-1:0]     wi;
    logic [ADDR_W:0]   end_addr;
    logic              err;
    logic              acc;
    logic              clr_en;
    logic              wr_en;
    logic [3:0][7:0]   rbytes;
    logic [31:0]       rdata;
    logic [3:0]        we;
    logic [3:0][7:0]   wb;

    // Range check is one bit wider than the address so it cannot wrap.
    assign wi       = c_addr[IW+1:2];
    assign end_addr = {1'b0, c_addr}
                    + (ADDR_W+1)'(size_bytes(c_size));
    assign err      = (c_size == 2'b11)
                   || (c_size == SZ_HALF && c_addr[0])
                   || (c_size == SZ_WORD && c_addr[1:0] != 2'b00)
                   || (end_addr > (ADDR_W+1)'(DEPTH_BYTES));

    assign acc    = (state == WAIT) && (cnt == 4'd0);
    assign clr_en = RST_N && (state == INIT);
    assign wr_en  = RST_N && acc && c_we && !err;
    assign rbytes = mem[wi];

    dmem_lanes u_lanes (
        .size   (c_size),
        .sgn    (c_signed),
        .off    (c_addr[1:0]),
        .wdata  (c_wdata),
        .rbytes (rbytes),
        .rdata  (rdata),
        .we     (we),
        .wb     (wb)
    );

    // Array update: word clear during init, lane store on good access
    always_ff @(posedge CLK) begin
        if (clr_en) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[wi][i] <= wb[i];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= INIT;
            clr_idx   <= '0;
            cnt       <= '0;
            c_we      <= 1'b0;
            c_size    <= SZ_BYTE;
            c_signed  <= 1'b0;
            c_addr    <= '0;
            c_wdata   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            init_done <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IW'(NW - 1)) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        c_we      <= req_we;
                        c_size    <= req_size;
                        c_signed  <= req_signed;
                        c_addr    <= req_addr;
                        c_wdata   <= req_wdata;
                        cnt       <= 4'(LATENCY);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || c_we) ? 32'd0 : rdata;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl at latencies 1, 0 and 5.
// Expected values are hand-computed big-endian results.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid  [3];
    logic        req_we     [3];
    logic        req_signed [3];
    logic [1:0]  req_size   [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        req_ready  [3];
    logic        rsp_valid  [3];
    logic        rsp_err    [3];
    logic        init_done  [3];
    logic [31:0] rsp_rdata  [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    dmem_ctrl #(.DEPTH_BYTES(128), .ADDR_W(32), .LATENCY(1)) u0 (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]),
        .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .init_done(init_done[0])
    );

    dmem_ctrl #(.DEPTH_BYTES(128), .ADDR_W(32), .LATENCY(0)) u1 (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]),
        .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .init_done(init_done[1])
    );

    dmem_ctrl #(.DEPTH_BYTES(128), .ADDR_W(32), .LATENCY(5)) u2 (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_size(req_size[2]),
        .req_signed(req_signed[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
        .init_done(init_done[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns data, error flag and the number of
    // edges from the accept edge to the one that raised rsp_valid.
    task automatic xact(input int k, input logic we,
                        input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        int n;
        n = 0;
        while (!req_ready[k] && n < 100) begin
            @(negedge CLK);
            n++;
        end
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_size[k]   = sz;
        req_signed[k] = sg;
        req_addr[k]   = a;
        req_wdata[k]  = wd;
        @(posedge CLK);
        @(negedge CLK);
        req_valid[k]  = 1'b0;
        req_we[k]     = ~we;
        req_size[k]   = 2'b11;
        req_signed[k] = ~sg;
        req_addr[k]   = 32'h5A5A_5A5A;
        req_wdata[k]  = 32'hFFFF_FFFF;
        lat = 0;
        while (!rsp_valid[k] && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        if (lat >= 40) chk("rsp_timeout", 32'(rsp_valid[k]), 32'd1);
        rd = rsp_rdata[k];
        er = rsp_err[k];
        @(negedge CLK);
        chk("pulse_width", 32'(rsp_valid[k]), 32'd0);
        chk("ready_back", 32'(req_ready[k]), 32'd1);
    endtask

    task automatic ld(input int k, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a,
                      input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(k, 1'b0, sz, sg, a, 32'd0, rd, er, lat);
        chk(tag, rd, exp);
        chk({tag, "_err"}, 32'(er), 32'd0);
    endtask

    task automatic st(input int k, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(k, 1'b1, sz, 1'b0, a, wd, rd, er, lat);
        chk({tag, "_rd"}, rd, 32'd0);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    task automatic bad(input logic [1:0] sz, input logic [31:0] a,
                       input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(0, 1'b0, sz, 1'b1, a, 32'd0, rd, er, lat);
        chk({tag, "_rd"}, rd, 32'd0);
        chk({tag, "_err"}, 32'(er), 32'd1);
    endtask

    task automatic chk_lat(input int k, input int exp_lat,
                           input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(k, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, rd, er, lat);
        chk(tag, 32'(lat), 32'(exp_lat));
    endtask

    // Hold req_valid high and measure response-to-response spacing.
    task automatic b2b(input int k, input int lat_p, input string tag);
        int n;
        int t0;
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b0;
        req_size[k]  = SZ_WORD;
        req_addr[k]  = 32'h0;
        n = 0;
        while (!rsp_valid[k] && n < 50) begin
            @(negedge CLK);
            n++;
        end
        t0 = cyc;
        @(negedge CLK);
        n = 0;
        while (!rsp_valid[k] && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'(cyc - t0), 32'(lat_p + 3));
        req_valid[k] = 1'b0;
        @(negedge CLK);
        chk({tag, "_idle"}, 32'(req_ready[k]), 32'd1);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done[0] && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'(n), 32'd32);
    endtask

    initial begin
        logic seen;
        for (int k = 0; k < 3; k++) begin
            req_valid[k]  = 1'b0;
            req_we[k]     = 1'b0;
            req_signed[k] = 1'b0;
            req_size[k]   = SZ_WORD;
            req_addr[k]   = '0;
            req_wdata[k]  = '0;
        end
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_err", 32'(rsp_err[0]), 32'd0);
        chk("rst_rdata", rsp_rdata[0], 32'd0);
        chk("rst_init", 32'(init_done[0]), 32'd0);
        req_valid[0] = 1'b1;
        RST_N = 1'b1;
        wait_init("init_cycles");
        req_valid[0] = 1'b0;
        chk("init_ready", 32'(req_ready[0]), 32'd1);
        chk("init_u2", 32'(init_done[2]), 32'd1);

        ld(0, SZ_WORD, 1'b0, 32'h10, 32'h0, "ld_w10_clear");

        st(0, SZ_WORD, 32'h04, 32'h8899_AABB, 1'b0, "st_w04");
        ld(0, SZ_WORD, 1'b0, 32'h04, 32'h8899_AABB, "ld_w04");
        ld(0, SZ_BYTE, 1'b1, 32'h05, 32'hFFFF_FF99, "ld_bs05");
        ld(0, SZ_BYTE, 1'b0, 32'h05, 32'h0000_0099, "ld_bu05");
        ld(0, SZ_HALF, 1'b0, 32'h06, 32'h0000_AABB, "ld_hu06");
        ld(0, SZ_HALF, 1'b1, 32'h04, 32'hFFFF_8899, "ld_hs04");
        ld(0, SZ_BYTE, 1'b1, 32'h07, 32'hFFFF_FFBB, "ld_bs07");
        ld(0, SZ_WORD, 1'b1, 32'h04, 32'h8899_AABB, "ld_ws04");

        st(0, SZ_BYTE, 32'h0B, 32'hFFFF_FF7F, 1'b0, "st_b0b");
        ld(0, SZ_WORD, 1'b0, 32'h08, 32'h0000_007F, "ld_w08a");
        st(0, SZ_HALF, 32'h0A, 32'hFFFF_1234, 1'b0, "st_h0a");
        ld(0, SZ_WORD, 1'b0, 32'h08, 32'h0000_1234, "ld_w08b");
        st(0, SZ_BYTE, 32'h08, 32'h0000_0080, 1'b0, "st_b08");
        ld(0, SZ_WORD, 1'b0, 32'h08, 32'h8000_1234, "ld_w08c");
        ld(0, SZ_BYTE, 1'b1, 32'h08, 32'hFFFF_FF80, "ld_bs08");
        ld(0, SZ_HALF, 1'b1, 32'h0A, 32'h0000_1234, "ld_hs0a");

        bad(SZ_WORD, 32'h02, "err_w02");
        bad(SZ_HALF, 32'h03, "err_h03");
        bad(SZ_WORD, 32'h80, "err_w80");
        bad(2'b11, 32'h00, "err_sz11");
        bad(SZ_BYTE, 32'h80, "err_b80");
        bad(SZ_HALF, 32'h7F, "err_h7f");
        bad(SZ_BYTE, 32'hFFFF_FFFF, "err_wrap");
        st(0, SZ_WORD, 32'h7C, 32'hCAFE_F00D, 1'b0, "st_w7c");
        ld(0, SZ_WORD, 1'b0, 32'h7C, 32'hCAFE_F00D, "ld_w7c");
        ld(0, SZ_BYTE, 1'b0, 32'h7F, 32'h0000_000D, "ld_b7f");
        st(0, SZ_WORD, 32'h06, 32'hFFFF_FFFF, 1'b1, "st_bad06");
        st(0, SZ_HALF, 32'h0B, 32'hFFFF_FFFF, 1'b1, "st_bad0b");
        st(0, SZ_WORD, 32'h80, 32'hFFFF_FFFF, 1'b1, "st_bad80");
        ld(0, SZ_WORD, 1'b0, 32'h04, 32'h8899_AABB, "ld_keep04");
        ld(0, SZ_WORD, 1'b0, 32'h08, 32'h8000_1234, "ld_keep08");

        chk_lat(1, 1, "lat0_edges");
        chk_lat(0, 2, "lat1_edges");
        chk_lat(2, 6, "lat5_edges");
        b2b(1, 0, "b2b_lat0");
        b2b(0, 1, "b2b_lat1");
        b2b(2, 5, "b2b_lat5");

        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_size[2]  = SZ_WORD;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'hDEAD_BEEF;
        @(posedge CLK);
        @(negedge CLK);
        req_valid[2] = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            seen = seen | rsp_valid[2];
        end
        chk("midrst_novalid", 32'(seen), 32'd0);
        chk("midrst_init", 32'(init_done[2]), 32'd0);
        chk("midrst_ready", 32'(req_ready[2]), 32'd0);
        RST_N = 1'b1;
        wait_init("reinit_cycles");
        ld(2, SZ_WORD, 1'b0, 32'h20, 32'h0, "ld_w20_after_rst");
        ld(0, SZ_WORD, 1'b0, 32'h04, 32'h0, "ld_w04_recleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
